// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-FIFO reader side: state encoding and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// BYTE_W is the FIFO data width and is also used by the FIFO itself, so both
// sides of the read interface agree on lane size.
package fifo_pkg;

    // Width of one FIFO entry / one lane of the packed word.
    localparam int BYTE_W    = 8;

    // Default number of bytes packed into one output word.
    localparam int DEF_BYTES = 4;

    // Reader FSM encoding; values are fixed so that waveforms decode the same
    // way across builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Drains a byte FIFO and packs BYTES bytes little-endian into one word; flush emits a partial word.
// Latency: word_valid rises 2*BYTES+1 cycles after the FIFO first shows non-empty (2 cycles per byte).
// Backpressure: while a word waits for word_ready no FIFO reads are issued; reads resume after the handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   fifo_empty  FIFO empty flag for the current cycle
//   fifo_data   FIFO read data, valid the cycle after a fifo_rd_en pulse
//   fifo_rd_en  FIFO read enable, registered single-cycle pulses
//   flush       request to emit whatever bytes have been collected
//   word_out    packed word, byte 0 in bits [7:0], unused lanes zero
//   word_bytes  number of valid bytes in word_out (1..BYTES)
//   word_valid  word_out/word_bytes valid
//   word_ready  downstream accepts on word_valid && word_ready at a rising edge
//   busy        high while not idle or while bytes are held
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int BYTES = DEF_BYTES,
    parameter int CNT_W = $clog2(BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    input  logic [BYTE_W-1:0]       fifo_data,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic [BYTE_W*BYTES-1:0] word_out,
    output logic [CNT_W-1:0]        word_bytes,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    busy
);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_byte_cnt;
    logic                      r_flush_pend;
    logic                      r_fifo_rd_en;
    logic                      r_word_valid;
    logic [BYTE_W*BYTES-1:0]   r_word;
    logic [CNT_W-1:0]          r_word_bytes;
    logic                      r_busy;

    logic [CNT_W-1:0]          w_cnt_inc;
    logic                      w_word_done;
    logic                      w_flush_req;
    logic [BYTES-1:0]          w_lane_we;

    // Byte count after the capture in progress, and whether that fills the word.
    always_comb begin
        w_cnt_inc   = r_byte_cnt + CNT_W'(1);
        w_word_done = (w_cnt_inc == CNT_W'(BYTES));
        w_flush_req = flush || r_flush_pend;
    end

    // One-hot lane select: only the lane addressed by byte_cnt is written, and
    // only in CAP, when fifo_data carries the byte read in the previous cycle.
    always_comb begin
        w_lane_we = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_lane_we[i] = (r_state == CAP) && (r_byte_cnt == CNT_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_byte_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_fifo_rd_en <= 1'b0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
            r_word_bytes <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A flush with nothing collected is dropped, not remembered.
                    if (w_flush_req && (r_byte_cnt != '0)) begin
                        r_state      <= HOLD;
                        r_word_bytes <= r_byte_cnt;
                        r_word_valid <= 1'b1;
                        r_flush_pend <= 1'b0;
                        r_busy       <= 1'b1;
                    end else if (!fifo_empty) begin
                        r_state      <= RD;
                        r_fifo_rd_en <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end

                RD: begin
                    // Read pulse lasts exactly this cycle; data arrives in CAP.
                    r_fifo_rd_en <= 1'b0;
                    r_state      <= CAP;
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end

                CAP: begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (w_lane_we[i]) begin
                            r_word[i*BYTE_W +: BYTE_W] <= fifo_data;
                        end
                    end
                    r_byte_cnt <= w_cnt_inc;

                    if (w_word_done) begin
                        // A pending flush is satisfied by the full word.
                        r_state      <= HOLD;
                        r_word_bytes <= CNT_W'(BYTES);
                        r_word_valid <= 1'b1;
                        r_flush_pend <= 1'b0;
                    end else if (!fifo_empty && !w_flush_req) begin
                        r_state      <= RD;
                        r_fifo_rd_en <= 1'b1;
                    end else begin
                        // Return to IDLE so a pending flush is honoured there
                        // rather than issuing another read.
                        r_state <= IDLE;
                        if (flush) begin
                            r_flush_pend <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Word and byte count stay frozen until accepted; flush
                    // and fifo_empty are ignored here.
                    if (word_ready) begin
                        r_state      <= IDLE;
                        r_word_valid <= 1'b0;
                        r_byte_cnt   <= '0;
                        r_word       <= '0;
                        r_word_bytes <= '0;
                        r_busy       <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_fifo_rd_en <= 1'b0;
                    r_word_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = r_fifo_rd_en;
    assign word_out   = r_word;
    assign word_bytes = r_word_bytes;
    assign word_valid = r_word_valid;
    assign busy       = r_busy;

endmodule
